// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, transmitter state encoding, legal parameter ranges.
// Used by uart_tx_cfg and intended for the matching receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int CLKS_PER_BIT_MIN = 2;
  localparam int DATA_BITS_MIN    = 5;
  localparam int DATA_BITS_MAX    = 9;
  localparam int STOP_BITS_MIN    = 1;
  localparam int STOP_BITS_MAX    = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  // Zero-extension to DATA_BITS_MAX leaves the XOR reduction unchanged.
  function automatic logic parity_of(input logic [DATA_BITS_MAX-1:0] data, input int parity);
    return (parity == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, held at 0 while clear is high.
// bit_end is high during the last cycle of each bit period.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 437,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  output logic o_Bit_End
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign o_Bit_End = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (i_Clear || o_Bit_End) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with one-word holding buffer; start bit one edge after accept,
// frames chain with no idle gap. Ready drops while the holding word is pending.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 437,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Tx_DV,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_cpb
    $error("uart_tx_cfg: CLKS_PER_BIT=%0d below minimum %0d", CLKS_PER_BIT, CLKS_PER_BIT_MIN);
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS=%0d outside %0d..%0d", DATA_BITS, DATA_BITS_MIN, DATA_BITS_MAX);
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_tx_cfg: PARITY=%0d is not a valid encoding", PARITY);
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS=%0d outside %0d..%0d", STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX);
  end

  tx_state_e            state_q,   state_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] hold_q,    hold_d;
  logic                 par_q,     par_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 ready_q,   ready_d;
  logic                 active_q,  active_d;
  logic                 serial_q,  serial_d;
  logic                 done_q,    done_d;

  logic bit_end;
  logic baud_clr;
  logic accept;
  logic busy;
  logic last_stop_end;

  assign baud_clr = (state_q == TX_IDLE);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (baud_clr),
    .o_Bit_End(bit_end)
  );

  assign accept        = i_Tx_DV & ready_q;
  assign busy          = (state_q == TX_START) || (state_q == TX_DATA) ||
                         (state_q == TX_PARITY) || (state_q == TX_STOP);
  assign last_stop_end = (state_q == TX_STOP) && bit_end && (stop_idx_q == LAST_STOP);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    ready_d    = ready_q;
    active_d   = active_q;
    serial_d   = serial_q;
    done_d     = 1'b0;

    // An accept coinciding with the final stop edge is handled below as a direct chain.
    if (accept && busy && !last_stop_end) begin
      hold_d  = i_Tx_Byte;
      ready_d = 1'b0;
    end

    case (state_q)
      TX_IDLE: begin
        if (accept) begin
          shift_d  = i_Tx_Byte;
          par_d    = parity_of(DATA_BITS_MAX'(i_Tx_Byte), PARITY);
          serial_d = 1'b0;
          active_d = 1'b1;
          state_d  = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          serial_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_idx_d = '0;
          state_d   = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            if (PARITY != PAR_NONE) begin
              serial_d = par_q;
              state_d  = TX_PARITY;
            end else begin
              serial_d = 1'b1;
              state_d  = TX_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            serial_d  = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      TX_PARITY: begin
        if (bit_end) begin
          serial_d   = 1'b1;
          stop_idx_d = 1'b0;
          state_d    = TX_STOP;
        end
      end
      TX_STOP: begin
        if (last_stop_end) begin
          done_d = 1'b1;
          if (!ready_q) begin
            shift_d  = hold_q;
            par_d    = parity_of(DATA_BITS_MAX'(hold_q), PARITY);
            ready_d  = 1'b1;
            serial_d = 1'b0;
            state_d  = TX_START;
          end else if (accept) begin
            shift_d  = i_Tx_Byte;
            par_d    = parity_of(DATA_BITS_MAX'(i_Tx_Byte), PARITY);
            serial_d = 1'b0;
            state_d  = TX_START;
          end else begin
            serial_d = 1'b1;
            active_d = 1'b0;
            state_d  = TX_IDLE;
          end
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      default: begin
        state_d    = TX_IDLE;
        serial_d   = 1'b1;
        active_d   = 1'b0;
        ready_d    = 1'b1;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= TX_IDLE;
      shift_q    <= '0;
      hold_q     <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      ready_q    <= 1'b1;
      active_q   <= 1'b0;
      serial_q   <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
      serial_q   <= serial_d;
      done_q     <= done_d;
    end
  end

  assign o_Tx_Ready  = ready_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg with four frame formats at CLKS_PER_BIT=4.
module tb_uart_tx_cfg;

  logic clk;
  logic rst;

  logic       dv0, dv1, dv2, dv3;
  logic [7:0] byte0, byte1, byte2;
  logic [6:0] byte3;
  logic       r0, a0, s0, d0;
  logic       r1, a1, s1, d1;
  logic       r2, a2, s2, d2;
  logic       r3, a3, s3, d3;

  int compared;
  int mismatched;

  logic sam [0:99];
  logic act [0:99];
  logic don [0:99];
  logic rdy [0:99];
  logic [0:23] exp_line;

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv0), .i_Tx_Byte(byte0),
    .o_Tx_Ready(r0), .o_Tx_Active(a0), .o_Tx_Serial(s0), .o_Tx_Done(d0));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv1), .i_Tx_Byte(byte1),
    .o_Tx_Ready(r1), .o_Tx_Active(a1), .o_Tx_Serial(s1), .o_Tx_Done(d1));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv2), .i_Tx_Byte(byte2),
    .o_Tx_Ready(r2), .o_Tx_Active(a2), .o_Tx_Serial(s2), .o_Tx_Done(d2));

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv3), .i_Tx_Byte(byte3),
    .o_Tx_Ready(r3), .o_Tx_Active(a3), .o_Tx_Serial(s3), .o_Tx_Done(d3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples n consecutive falling edges of the selected instance into the capture arrays.
  task automatic capture(input int sel, input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      @(negedge clk);
      case (sel)
        0: begin sam[i] = s0; act[i] = a0; don[i] = d0; rdy[i] = r0; end
        1: begin sam[i] = s1; act[i] = a1; don[i] = d1; rdy[i] = r1; end
        2: begin sam[i] = s2; act[i] = a2; don[i] = d2; rdy[i] = r2; end
        default: begin sam[i] = s3; act[i] = a3; don[i] = d3; rdy[i] = r3; end
      endcase
    end
  endtask

  function automatic int count_act(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (act[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_done(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (don[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int nth_done(input int n, input int which);
    int c = 0;
    for (int i = 0; i < n; i++) begin
      if (don[i] === 1'b1) begin
        if (c == which) return i;
        c++;
      end
    end
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    #1;
    compared++; if (s0 !== 1'b1) begin mismatched++; $display("FAIL reset_serial: got %b want 1", s0); end
    compared++; if (r0 !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", r0); end
    compared++; if (a0 !== 1'b0) begin mismatched++; $display("FAIL reset_active: got %b want 0", a0); end
    compared++; if (d0 !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", d0); end
    compared++; if (s3 !== 1'b1) begin mismatched++; $display("FAIL reset_serial_7n2: got %b want 1", s3); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    capture(0, 0, 2);
  endtask

  task automatic test_8n1;
    logic bad;
    exp_line = '1;
    exp_line[0:11] = 12'b010100101111;
    byte0 = 8'hA5; dv0 = 1'b1;
    capture(0, 0, 1);
    dv0 = 1'b0;
    capture(0, 1, 47);
    for (int k = 0; k < 12; k++) begin
      bad = 1'b0;
      for (int c = 0; c < 4; c++) if (sam[k*4+c] !== exp_line[k]) bad = 1'b1;
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL 8n1_bit%0d: got %b%b%b%b want %b", k, sam[k*4], sam[k*4+1], sam[k*4+2], sam[k*4+3], exp_line[k]);
      end
    end
    compared++; if (count_act(48) != 40) begin mismatched++; $display("FAIL 8n1_active_len: got %0d want 40", count_act(48)); end
    compared++; if (count_done(48) != 1) begin mismatched++; $display("FAIL 8n1_done_cnt: got %0d want 1", count_done(48)); end
    compared++; if (nth_done(48, 0) != 40) begin mismatched++; $display("FAIL 8n1_done_pos: got %0d want 40", nth_done(48, 0)); end
    compared++; if (rdy[0] !== 1'b1) begin mismatched++; $display("FAIL 8n1_ready_busy: got %b want 1", rdy[0]); end
  endtask

  task automatic test_parity;
    logic bad;
    for (int sel = 1; sel <= 2; sel++) begin
      exp_line = '1;
      exp_line[0:11] = (sel == 1) ? 12'b011100000111 : 12'b011100000011;
      if (sel == 1) begin byte1 = 8'h07; dv1 = 1'b1; end
      else begin byte2 = 8'h07; dv2 = 1'b1; end
      capture(sel, 0, 1);
      dv1 = 1'b0; dv2 = 1'b0;
      capture(sel, 1, 47);
      for (int k = 0; k < 12; k++) begin
        bad = 1'b0;
        for (int c = 0; c < 4; c++) if (sam[k*4+c] !== exp_line[k]) bad = 1'b1;
        compared++;
        if (bad) begin
          mismatched++;
          $display("FAIL parity%0d_bit%0d: got %b%b%b%b want %b", sel, k, sam[k*4], sam[k*4+1], sam[k*4+2], sam[k*4+3], exp_line[k]);
        end
      end
      compared++;
      if (count_act(48) != 44) begin mismatched++; $display("FAIL parity%0d_active_len: got %0d want 44", sel, count_act(48)); end
      compared++;
      if (nth_done(48, 0) != 44) begin mismatched++; $display("FAIL parity%0d_done_pos: got %0d want 44", sel, nth_done(48, 0)); end
    end
  endtask

  task automatic test_7n2;
    logic bad;
    exp_line = '1;
    exp_line[0:11] = 12'b010000011111;
    byte3 = 7'h41; dv3 = 1'b1;
    capture(3, 0, 1);
    dv3 = 1'b0;
    capture(3, 1, 47);
    for (int k = 0; k < 12; k++) begin
      bad = 1'b0;
      for (int c = 0; c < 4; c++) if (sam[k*4+c] !== exp_line[k]) bad = 1'b1;
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL 7n2_bit%0d: got %b%b%b%b want %b", k, sam[k*4], sam[k*4+1], sam[k*4+2], sam[k*4+3], exp_line[k]);
      end
    end
    compared++; if (count_act(48) != 40) begin mismatched++; $display("FAIL 7n2_active_len: got %0d want 40", count_act(48)); end
    compared++; if (nth_done(48, 0) != 40) begin mismatched++; $display("FAIL 7n2_done_pos: got %0d want 40", nth_done(48, 0)); end
  endtask

  task automatic test_back_to_back;
    logic bad;
    exp_line = '1;
    exp_line[0:21] = 22'b0101010101011110000111;
    byte0 = 8'h55; dv0 = 1'b1;
    capture(0, 0, 1);
    byte0 = 8'h0F;
    capture(0, 1, 1);
    dv0 = 1'b0;
    compared++; if (rdy[1] !== 1'b0) begin mismatched++; $display("FAIL b2b_ready_low: got %b want 0", rdy[1]); end
    capture(0, 2, 86);
    for (int k = 0; k < 22; k++) begin
      bad = 1'b0;
      for (int c = 0; c < 4; c++) if (sam[k*4+c] !== exp_line[k]) bad = 1'b1;
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL b2b_bit%0d: got %b%b%b%b want %b", k, sam[k*4], sam[k*4+1], sam[k*4+2], sam[k*4+3], exp_line[k]);
      end
    end
    compared++; if (count_act(88) != 80) begin mismatched++; $display("FAIL b2b_active_len: got %0d want 80", count_act(88)); end
    compared++; if (count_done(88) != 2) begin mismatched++; $display("FAIL b2b_done_cnt: got %0d want 2", count_done(88)); end
    compared++; if (nth_done(88, 0) != 40) begin mismatched++; $display("FAIL b2b_done0_pos: got %0d want 40", nth_done(88, 0)); end
    compared++; if (nth_done(88, 1) != 80) begin mismatched++; $display("FAIL b2b_done1_pos: got %0d want 80", nth_done(88, 1)); end
    compared++; if (rdy[40] !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_drain: got %b want 1", rdy[40]); end
  endtask

  task automatic test_ignore_busy;
    logic bad;
    exp_line = '1;
    exp_line[0:21] = 22'b0100000011001001000111;
    byte0 = 8'h81; dv0 = 1'b1;
    capture(0, 0, 1);
    byte0 = 8'h12;
    capture(0, 1, 1);
    dv0 = 1'b0;
    capture(0, 2, 1);
    byte0 = 8'hFF; dv0 = 1'b1;
    capture(0, 3, 1);
    dv0 = 1'b0;
    capture(0, 4, 84);
    compared++; if (rdy[3] !== 1'b0) begin mismatched++; $display("FAIL ign_ready_low: got %b want 0", rdy[3]); end
    for (int k = 0; k < 22; k++) begin
      bad = 1'b0;
      for (int c = 0; c < 4; c++) if (sam[k*4+c] !== exp_line[k]) bad = 1'b1;
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL ign_bit%0d: got %b%b%b%b want %b", k, sam[k*4], sam[k*4+1], sam[k*4+2], sam[k*4+3], exp_line[k]);
      end
    end
    compared++; if (count_act(88) != 80) begin mismatched++; $display("FAIL ign_active_len: got %0d want 80", count_act(88)); end
    compared++; if (count_done(88) != 2) begin mismatched++; $display("FAIL ign_done_cnt: got %0d want 2", count_done(88)); end
  endtask

  task automatic test_async_reset;
    logic bad;
    byte0 = 8'h00; dv0 = 1'b1;
    capture(0, 0, 1);
    byte0 = 8'hAA;
    capture(0, 1, 1);
    dv0 = 1'b0;
    capture(0, 2, 16);
    compared++; if (sam[17] !== 1'b0) begin mismatched++; $display("FAIL rst_pre_serial: got %b want 0", sam[17]); end
    compared++; if (rdy[17] !== 1'b0) begin mismatched++; $display("FAIL rst_pre_ready: got %b want 0", rdy[17]); end
    #2 rst = 1'b1;
    #1;
    compared++; if (s0 !== 1'b1) begin mismatched++; $display("FAIL rst_async_serial: got %b want 1", s0); end
    compared++; if (a0 !== 1'b0) begin mismatched++; $display("FAIL rst_async_active: got %b want 0", a0); end
    compared++; if (r0 !== 1'b1) begin mismatched++; $display("FAIL rst_async_ready: got %b want 1", r0); end
    @(negedge clk);
    rst = 1'b0;
    capture(0, 0, 3);
    exp_line = '1;
    exp_line[0:11] = 12'b000111100111;
    byte0 = 8'h3C; dv0 = 1'b1;
    capture(0, 0, 1);
    dv0 = 1'b0;
    capture(0, 1, 47);
    for (int k = 0; k < 12; k++) begin
      bad = 1'b0;
      for (int c = 0; c < 4; c++) if (sam[k*4+c] !== exp_line[k]) bad = 1'b1;
      compared++;
      if (bad) begin
        mismatched++;
        $display("FAIL rst_after_bit%0d: got %b%b%b%b want %b", k, sam[k*4], sam[k*4+1], sam[k*4+2], sam[k*4+3], exp_line[k]);
      end
    end
    compared++; if (count_act(48) != 40) begin mismatched++; $display("FAIL rst_after_active_len: got %0d want 40", count_act(48)); end
    compared++; if (count_done(48) != 1) begin mismatched++; $display("FAIL rst_after_done_cnt: got %0d want 1", count_done(48)); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst   = 1'b1;
    dv0 = 1'b0; dv1 = 1'b0; dv2 = 1'b0; dv3 = 1'b0;
    byte0 = '0; byte1 = '0; byte2 = '0; byte3 = '0;
    test_reset;
    test_8n1;
    test_parity;
    test_7n2;
    test_back_to_back;
    test_ignore_busy;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
